// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a 1-cycle-latency dual-port RAM,
// with a 2-entry output buffer (head + skid) to sustain one word per clock.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LVL_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]  level,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned BUF_W = 3;

  logic [ADDR_W-1:0] wptr, rptr;
  logic [LVL_W-1:0]  ram_cnt, ram_cnt_nxt, level_nxt;
  logic              rd_pend;
  logic              skid_v;
  logic [DATA_W-1:0] skid;

  logic              push, pop;
  logic [BUF_W-1:0]  buf_cnt, buf_cnt_nxt;
  logic              head_v_nxt, skid_v_nxt;
  logic [DATA_W-1:0] head_nxt, skid_nxt;
  logic [ADDR_W-1:0] wptr_inc, rptr_inc;

  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign buf_cnt   = BUF_W'(out_valid) + BUF_W'(skid_v);

  assign ram_wen   = push;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;
  assign ram_din   = in_data;

  assign wptr_inc  = (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + ADDR_W'(1);
  assign rptr_inc  = (rptr == ADDR_W'(DEPTH - 1)) ? '0 : rptr + ADDR_W'(1);

  // Read issue: only while the buffer plus the in-flight read leaves room after this cycle's pop
  always_comb begin
    ram_ren = 1'b0;
    if (!flush && ram_cnt != '0 &&
        (buf_cnt + BUF_W'(rd_pend)) < (BUF_W'(2) + BUF_W'(pop))) begin
      ram_ren = 1'b1;
    end
  end

  assign ram_cnt_nxt = ram_cnt + LVL_W'(push) - LVL_W'(ram_ren);

  // Output buffer: pop shifts skid to head, then the RAM return fills the first free slot
  always_comb begin
    head_v_nxt = out_valid;
    skid_v_nxt = skid_v;
    head_nxt   = out_data;
    skid_nxt   = skid;
    if (pop) begin
      if (skid_v) begin
        head_nxt   = skid;
        skid_v_nxt = 1'b0;
      end else begin
        head_v_nxt = 1'b0;
      end
    end
    if (rd_pend) begin
      if (!head_v_nxt) begin
        head_nxt   = ram_dout;
        head_v_nxt = 1'b1;
      end else begin
        skid_nxt   = ram_dout;
        skid_v_nxt = 1'b1;
      end
    end
  end

  assign buf_cnt_nxt = BUF_W'(head_v_nxt) + BUF_W'(skid_v_nxt);
  assign level_nxt   = ram_cnt_nxt + LVL_W'(ram_ren) + LVL_W'(buf_cnt_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_v    <= 1'b0;
      skid      <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_v    <= 1'b0;
      skid      <= '0;
      level     <= '0;
      in_ready  <= 1'b1;
    end else begin
      if (push) wptr <= wptr_inc;
      if (ram_ren) rptr <= rptr_inc;
      ram_cnt   <= ram_cnt_nxt;
      rd_pend   <= ram_ren;
      out_valid <= head_v_nxt;
      out_data  <= head_nxt;
      skid_v    <= skid_v_nxt;
      skid      <= skid_nxt;
      level     <= level_nxt;
      in_ready  <= (ram_cnt_nxt < LVL_W'(DEPTH));
    end
  end

endmodule
